rom_fetch_ctrl: RTL and testbench
=================================

Name: rom_fetch_ctrl

Overview:
Sequencer and arbiter in front of the 64-word combinational instruction ROM. It owns the fetch PC and issues one ROM read per cycle into a registered output slot with a valid/ready handshake toward decode. It accepts branch/jump redirects. A debug read port shares the same ROM, and an anti-starvation counter bounds debug latency.

Parameters:
PC_W, 64, fetch PC / address width (matches InstAddrBus)
RESET_PC, 64'h0, PC loaded on reset
IDX_W, 6, ROM word-index width (64 entries)
DBG_WAIT, 4, max consecutive cycles a pending dbg_req may be denied before forced grant

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
redirect_valid  in  1  load redirect_pc as next fetch PC
redirect_pc  in  PC_W  redirect target
out_valid  out  1  out_pc/out_inst hold a fetched instruction
out_ready  in  1  decode accepts slot this cycle
out_pc  out  PC_W  PC of slotted instruction
out_inst  out  32  slotted instruction word
dbg_req  in  1  debug read request, held until dbg_ack
dbg_idx  in  IDX_W  ROM word index for debug read
dbg_ack  out  1  one-cycle pulse, dbg_data valid
dbg_data  out  32  debug read result
rom_ce  out  1  to ROM ce
rom_addr  out  PC_W  to ROM addr; word index in bits [IDX_W-1:0]
rom_inst  in  32  from ROM inst (combinational)

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_PC, out_valid=0, out_pc=0, out_inst=0, dbg_ack=0, dbg_data=0, wait_cnt=0. rom_ce=0 while in reset.
- slot_free = !out_valid | out_ready. fire = out_valid & out_ready.
- Grant, evaluated combinationally each cycle, first match wins:
  1. redirect_valid: no ROM access this cycle (rom_ce=0).
  2. dbg_req & (wait_cnt==DBG_WAIT | !slot_free): debug grant.
  3. slot_free: fetch grant.
  4. Otherwise idle.
- Fetch grant: rom_ce=1, rom_addr=pc>>2, zero-extended. So ROM index = pc[IDX_W+1:2]; PCs beyond 64 words wrap modulo 64, with no error. On the edge: out_valid<=1, out_pc<=pc, out_inst<=rom_inst, pc<=pc+4. Latency is 1 cycle from issue to out_valid.
- Debug grant: rom_ce=1, rom_addr=dbg_idx (zero-extended). On the edge: dbg_data<=rom_inst, dbg_ack<=1, wait_cnt<=0. The fetch slot is unchanged, and its fire is still honoured.
- dbg_ack is high for exactly one cycle. The requester drops dbg_req in the ack cycle. A dbg_req still high in the ack cycle is a new request.
- wait_cnt increments (saturating at DBG_WAIT) each cycle dbg_req=1 without debug grant. It clears on grant or when dbg_req=0.
- Redirect: on the edge pc<=redirect_pc with bits [1:0] forced to 0, and out_valid<=0 (flush, even if not fired). A slot that fires in the same cycle counts as consumed. A pending debug request waits; wait_cnt still counts.
- Idle / no grant: out_valid holds. If fire occurred with no new fetch, out_valid<=0.
- Stall (out_valid & !out_ready): out_pc/out_inst stable, pc not advanced.
- rom_ce=0 implies rom_addr=0.
- Back-to-back: with out_ready=1 held, one instruction per cycle with no bubbles, except debug-forced or redirect cycles.

Decomposition:
- Shared package/defines: RESET_PC value, ROM depth/IDX_W, instruction width 32, NOP word (32'h00000013) for bench compare.
- One natural sub-module: rom_fetch_arb. It holds the combinational grant logic plus wait_cnt, and outputs gnt_fetch/gnt_dbg. The top holds pc, the output slot and debug registers, and drives the ROM mux.

Test Plan:
- Reset release with out_ready=1 and ROM words 0..3 = 32'h1,2,3,4: out_valid rises 1 cycle later. Outputs (out_pc, out_inst) = (0,1), (4,2), (8,3), (C,4) on consecutive cycles.
- Stall: out_ready=0 for 3 cycles after first word: out_pc=0 and out_inst=1 held, rom_ce=0. Release gives 4/2 next, with no skipped or duplicated word.
- Redirect to 64'h22 while out_valid=1, out_ready=0: slot flushed next cycle (out_valid=0). The next word is pc=0x20, inst=rom[8].
- dbg_req with dbg_idx=5 during stall: dbg_ack is asserted after 1 cycle with dbg_data=rom[5], and the slot is unchanged.
- dbg_req with dbg_idx=7 during continuous fetch (out_ready=1), DBG_WAIT=4: ack on the 6th cycle, one fetch bubble, dbg_data=rom[7], PC sequence continuous.
- Fetch from pc=0xFC then 0x100: out_inst=rom[63] then rom[0] (wrap). Assert rst_n=0 mid-stream: outputs zero immediately.

Source files
------------

// File: rtl/rom_fetch_ctrl_pkg.sv
// rtl/rom_fetch_ctrl_pkg.sv - shared constants and grant encoding for the ROM fetch controller
package rom_fetch_ctrl_pkg;

   localparam int                INST_W        = 32;
   localparam int                ROM_DEPTH     = 64;
   localparam int                ROM_IDX_W     = $clog2(ROM_DEPTH);
   localparam logic [63:0]       RESET_PC_DFLT = 64'h0;
   localparam logic [INST_W-1:0] NOP_INST      = 32'h0000_0013;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_FETCH,
      GNT_DBG,
      GNT_REDIR
   } gnt_e;

endpackage

// File: rtl/rom_fetch_arb.sv
// rtl/rom_fetch_arb.sv - ROM port arbitration between fetch and debug with bounded debug latency
module rom_fetch_arb
   import rom_fetch_ctrl_pkg::*;
#(
   parameter int DBG_WAIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic redirect_valid,
   input  logic dbg_req,
   input  logic slot_free,
   output logic gnt_fetch,
   output logic gnt_dbg
);

   localparam int CNT_W = $clog2(DBG_WAIT + 2);

   logic [CNT_W-1:0] wait_cnt;
   logic             wait_max;
   gnt_e             gnt;

   assign wait_max = (wait_cnt == CNT_W'(DBG_WAIT));

   // Debug wins outright when the fetch slot is blocked anyway, or once it has waited long enough.
   always_comb begin
      gnt = GNT_NONE;
      if (redirect_valid) begin
         gnt = GNT_REDIR;
      end else if (dbg_req && (wait_max || !slot_free)) begin
         gnt = GNT_DBG;
      end else if (slot_free) begin
         gnt = GNT_FETCH;
      end
   end

   assign gnt_fetch = (gnt == GNT_FETCH);
   assign gnt_dbg   = (gnt == GNT_DBG);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (!dbg_req || gnt_dbg) begin
         wait_cnt <= '0;
      end else if (!wait_max) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/rom_fetch_ctrl.sv
// rtl/rom_fetch_ctrl.sv - fetch PC sequencer with registered output slot and shared debug ROM port
module rom_fetch_ctrl
   import rom_fetch_ctrl_pkg::*;
#(
   parameter int              PC_W     = 64,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DFLT),
   parameter int              IDX_W    = ROM_IDX_W,
   parameter int              DBG_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [INST_W-1:0] out_inst,
   input  logic              dbg_req,
   input  logic [IDX_W-1:0]  dbg_idx,
   output logic              dbg_ack,
   output logic [INST_W-1:0] dbg_data,
   output logic              rom_ce,
   output logic [PC_W-1:0]   rom_addr,
   input  logic [INST_W-1:0] rom_inst
);

   logic [PC_W-1:0] pc;
   logic            slot_free;
   logic            fire;
   logic            gnt_fetch;
   logic            gnt_dbg;

   assign slot_free = !out_valid || out_ready;
   assign fire      = out_valid && out_ready;

   rom_fetch_arb #(
      .DBG_WAIT (DBG_WAIT)
   ) u_arb (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .dbg_req        (dbg_req),
      .slot_free      (slot_free),
      .gnt_fetch      (gnt_fetch),
      .gnt_dbg        (gnt_dbg)
   );

   assign rom_ce = rst_n && (gnt_fetch || gnt_dbg);

   // Address stays zero whenever the ROM is not enabled, including during reset.
   always_comb begin
      rom_addr = '0;
      if (rst_n && gnt_dbg) begin
         rom_addr = PC_W'(dbg_idx);
      end else if (rst_n && gnt_fetch) begin
         rom_addr = pc >> 2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc        <= RESET_PC;
         out_valid <= 1'b0;
         out_pc    <= '0;
         out_inst  <= '0;
      end else if (redirect_valid) begin
         pc        <= {redirect_pc[PC_W-1:2], 2'b00};
         out_valid <= 1'b0;
      end else if (gnt_fetch) begin
         out_valid <= 1'b1;
         out_pc    <= pc;
         out_inst  <= rom_inst;
         pc        <= pc + PC_W'(4);
      end else if (fire) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbg_ack  <= 1'b0;
         dbg_data <= '0;
      end else begin
         dbg_ack <= gnt_dbg;
         if (gnt_dbg) begin
            dbg_data <= rom_inst;
         end
      end
   end

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// tb/tb_rom_fetch_ctrl.sv - self-checking bench for rom_fetch_ctrl against a behavioural model
module tb_rom_fetch_ctrl;
   import rom_fetch_ctrl_pkg::*;

   localparam int PC_W     = 64;
   localparam int IDX_W    = 6;
   localparam int DBG_WAIT = 4;

   logic              clk            = 1'b0;
   logic              rst_n          = 1'b0;
   logic              redirect_valid = 1'b0;
   logic [PC_W-1:0]   redirect_pc    = '0;
   logic              out_ready      = 1'b0;
   logic              dbg_req        = 1'b0;
   logic [IDX_W-1:0]  dbg_idx        = '0;
   logic              out_valid;
   logic [PC_W-1:0]   out_pc;
   logic [31:0]       out_inst;
   logic              dbg_ack;
   logic [31:0]       dbg_data;
   logic              rom_ce;
   logic [PC_W-1:0]   rom_addr;
   logic [31:0]       rom_inst;

   logic [31:0] mem [64];
   assign rom_inst = mem[rom_addr[5:0]];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rom_fetch_ctrl #(
      .PC_W     (PC_W),
      .RESET_PC (64'h0),
      .IDX_W    (IDX_W),
      .DBG_WAIT (DBG_WAIT)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_inst       (out_inst),
      .dbg_req        (dbg_req),
      .dbg_idx        (dbg_idx),
      .dbg_ack        (dbg_ack),
      .dbg_data       (dbg_data),
      .rom_ce         (rom_ce),
      .rom_addr       (rom_addr),
      .rom_inst       (rom_inst)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Behavioural model: what decode and the debug port must observe.
   logic [63:0] m_pc    = 64'h0;
   logic [63:0] m_opc   = 64'h0;
   logic [31:0] m_oinst = 32'h0;
   logic [31:0] m_data  = 32'h0;
   bit          m_valid = 1'b0;
   bit          m_ack   = 1'b0;
   int          m_wait  = 0;

   // 0 idle, 1 fetch, 2 debug, 3 redirect
   function automatic int model_grant();
      bit free;
      free = !m_valid || out_ready;
      if (redirect_valid) return 3;
      if (dbg_req && (m_wait == DBG_WAIT || !free)) return 2;
      if (free) return 1;
      return 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int g;
      bit fire;
      if (!rst_n) begin
         m_pc = 64'h0; m_opc = 64'h0; m_oinst = 32'h0; m_data = 32'h0;
         m_valid = 1'b0; m_ack = 1'b0; m_wait = 0;
      end else begin
         g    = model_grant();
         fire = m_valid && out_ready;
         m_ack = (g == 2);
         if (g == 2) m_data = mem[dbg_idx];
         if (dbg_req && g != 2) m_wait = (m_wait < DBG_WAIT) ? m_wait + 1 : DBG_WAIT;
         else m_wait = 0;
         if (g == 3) begin
            m_pc    = {redirect_pc[63:2], 2'b00};
            m_valid = 1'b0;
         end else if (g == 1) begin
            m_valid = 1'b1;
            m_opc   = m_pc;
            m_oinst = mem[m_pc[7:2]];
            m_pc    = m_pc + 64'd4;
         end else if (fire) begin
            m_valid = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      int g;
      logic [63:0] ea;
      bit ece;
      g   = model_grant();
      ece = rst_n && (g == 1 || g == 2);
      ea  = 64'h0;
      if (ece && g == 1) ea = m_pc >> 2;
      if (ece && g == 2) ea = 64'(dbg_idx);
      chk("out_valid", out_valid, m_valid);
      chk("out_pc", out_pc, m_opc);
      chk("out_inst", out_inst, m_oinst);
      chk("dbg_ack", dbg_ack, m_ack);
      chk("dbg_data", dbg_data, m_data);
      chk("rom_ce", rom_ce, ece);
      chk("rom_addr", rom_addr, ea);
      if (out_valid) chk("slot_word_matches_rom", out_inst, mem[out_pc[7:2]]);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      if (dbg_ack) dbg_req = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'(i + 1);
      repeat (2) cyc();
      chk("rst_valid", out_valid, 0);
      chk("rst_pc", out_pc, 0);
      chk("rst_ce", rom_ce, 0);

      // Reset release, streaming fetch
      out_ready = 1'b1;
      rst_n     = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("t1_valid", out_valid, 1);
         chk("t1_pc", out_pc, 64'(4 * k));
         chk("t1_inst", out_inst, 64'(k + 1));
      end

      // Stall after first word
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      chk("t2_first_pc", out_pc, 0);
      out_ready = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("t2_stall_ce", rom_ce, 0);
         cyc();
         chk("t2_hold_pc", out_pc, 0);
         chk("t2_hold_inst", out_inst, 1);
      end
      out_ready = 1'b1;
      cyc();
      chk("t2_next_pc", out_pc, 64'h4);
      chk("t2_next_inst", out_inst, 2);
      out_ready = 1'b0;

      // Redirect while stalled
      redirect_valid = 1'b1;
      redirect_pc    = 64'h22;
      cyc();
      redirect_valid = 1'b0;
      chk("t3_flush", out_valid, 0);
      cyc();
      chk("t3_valid", out_valid, 1);
      chk("t3_pc", out_pc, 64'h20);
      chk("t3_inst", out_inst, 9);

      // Debug read during stall
      dbg_req = 1'b1;
      dbg_idx = 6'd5;
      cyc();
      chk("t4_ack", dbg_ack, 1);
      chk("t4_data", dbg_data, 6);
      chk("t4_slot_pc", out_pc, 64'h20);
      chk("t4_slot_inst", out_inst, 9);
      cyc();
      chk("t4_ack_pulse", dbg_ack, 0);

      // Debug read against continuous fetch: forced grant after DBG_WAIT denials
      out_ready = 1'b1;
      dbg_req   = 1'b1;
      dbg_idx   = 6'd7;
      for (int k = 1; k <= 4; k++) begin
         cyc();
         chk("t5_no_ack", dbg_ack, 0);
         chk("t5_pc", out_pc, 64'h20 + 64'(4 * k));
      end
      cyc();
      chk("t5_ack", dbg_ack, 1);
      chk("t5_data", dbg_data, 8);
      chk("t5_bubble", out_valid, 0);
      cyc();
      chk("t5_resume_pc", out_pc, 64'h34);
      chk("t5_resume_inst", out_inst, 14);

      // Wrap past 64 words, then asynchronous reset mid-stream
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFC;
      cyc();
      redirect_valid = 1'b0;
      cyc();
      chk("t6_pc_fc", out_pc, 64'hFC);
      chk("t6_inst_63", out_inst, 64);
      cyc();
      chk("t6_pc_100", out_pc, 64'h100);
      chk("t6_inst_wrap", out_inst, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_pc", out_pc, 0);
      chk("t6_rst_inst", out_inst, 0);
      chk("t6_rst_ce", rom_ce, 0);

      // Randomized traffic
      repeat (2) cyc();
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      rst_n = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         cyc();
         out_ready      = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc    = {$urandom, $urandom};
         if (!dbg_req && $urandom_range(0, 7) == 0) begin
            dbg_req = 1'b1;
            dbg_idx = 6'($urandom_range(0, 63));
         end
      end
      cyc();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
